// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and constants for the KLP32V1 trace UART.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] wb;
      logic [7:0]  flags;
   } trace_rec_t;

   localparam int FRAME_BYTES = 14;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam int FLAG_PCSEL    = 7;
   localparam int FLAG_BREQ     = 6;
   localparam int FLAG_BRLT     = 5;
   localparam int FLAG_REGWEN   = 4;
   localparam int FLAG_MEMRW    = 3;
   localparam int FLAG_WBSEL_LO = 1;

   // Byte idx of a frame: sync, pc, inst, wb (each little-endian), flags.
   function automatic logic [7:0] frame_byte(input trace_rec_t r, input logic [3:0] idx,
                                             input logic [7:0] sync);
      logic [7:0] b;
      case (idx)
         4'd0:    b = sync;
         4'd1:    b = r.pc[7:0];
         4'd2:    b = r.pc[15:8];
         4'd3:    b = r.pc[23:16];
         4'd4:    b = r.pc[31:24];
         4'd5:    b = r.inst[7:0];
         4'd6:    b = r.inst[15:8];
         4'd7:    b = r.inst[23:16];
         4'd8:    b = r.inst[31:24];
         4'd9:    b = r.wb[7:0];
         4'd10:   b = r.wb[15:8];
         4'd11:   b = r.wb[23:16];
         4'd12:   b = r.wb[31:24];
         4'd13:   b = r.flags;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trace_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : trace_uart_tx_if
//  Description : Processor observation bundle sampled by the trace UART.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trace_uart_tx_if;
   logic        i_capture;
   logic [31:0] i_pcOut;
   logic [31:0] i_inst;
   logic [31:0] i_writeBack;
   logic [1:0]  i_wb_select;
   logic        i_PCSel;
   logic        i_BrEq;
   logic        i_BrLT;
   logic        i_RegWEn;
   logic        i_memRW;

   modport master (
      output i_capture, i_pcOut, i_inst, i_writeBack, i_wb_select,
             i_PCSel, i_BrEq, i_BrLT, i_RegWEn, i_memRW
   );

   modport slave (
      input  i_capture, i_pcOut, i_inst, i_writeBack, i_wb_select,
             i_PCSel, i_BrEq, i_BrLT, i_RegWEn, i_memRW
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serializer; accepts the next byte in the last stop cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
   import trace_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  wire        clk,
   input  wire        rst_n,
   input  wire        i_start,
   input  wire  [7:0] i_data,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_busy
);
   localparam int         CW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d;
   logic          w_bit_end;

   assign w_bit_end = (cnt_q == c_last);
   assign o_ready   = (state_q == ST_IDLE) || ((state_q == ST_STOP) && w_bit_end);
   assign o_tx      = tx_q;
   assign o_busy    = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      case (state_q)
         ST_IDLE: tx_d = 1'b1;
         ST_START: begin
            if (w_bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               tx_d    = shreg_q[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_d    = shreg_q[1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A new byte overrides the stop->idle step so bytes run gap-free.
      if (i_start && o_ready) begin
         state_d = ST_START;
         cnt_d   = '0;
         shreg_d = i_data;
         tx_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/trace_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : trace_uart_tx
//  Description : Captures retired-instruction records into a FIFO and frames them out a UART.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_uart_tx
   import trace_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  wire               clk,
   input  wire               reset_in,
   trace_uart_tx_if.slave    obs,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_full,
   output logic [7:0]        o_drop_count
);
   localparam int            PW      = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   c_depth = (PW + 1)'(FIFO_DEPTH);
   localparam logic [3:0]    c_last  = 4'(FRAME_BYTES);

   trace_rec_t    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic [7:0]    drop_q, drop_d;
   logic          active_q, active_d;
   logic [3:0]    idx_q, idx_d;
   trace_rec_t    rec_q, rec_d;

   trace_rec_t    w_rec_in;
   logic          w_push, w_pop, w_drop, w_empty, w_ready, w_start;
   logic [7:0]    w_data;

   always_comb begin
      w_rec_in.pc    = obs.i_pcOut;
      w_rec_in.inst  = obs.i_inst;
      w_rec_in.wb    = obs.i_writeBack;
      w_rec_in.flags = '0;
      w_rec_in.flags[FLAG_PCSEL]          = obs.i_PCSel;
      w_rec_in.flags[FLAG_BREQ]           = obs.i_BrEq;
      w_rec_in.flags[FLAG_BRLT]           = obs.i_BrLT;
      w_rec_in.flags[FLAG_REGWEN]         = obs.i_RegWEn;
      w_rec_in.flags[FLAG_MEMRW]          = obs.i_memRW;
      w_rec_in.flags[FLAG_WBSEL_LO +: 2]  = obs.i_wb_select;
   end

   assign w_empty = (count_q == '0);

   // Frame sequencing: each serializer ready slot gets the next byte or the next record.
   always_comb begin
      w_pop    = 1'b0;
      w_start  = 1'b0;
      w_data   = 8'h00;
      active_d = active_q;
      idx_d    = idx_q;
      rec_d    = rec_q;
      if (w_ready) begin
         if (active_q && (idx_q != c_last)) begin
            w_start = 1'b1;
            w_data  = frame_byte(rec_q, idx_q, SYNC_BYTE);
            idx_d   = idx_q + 4'd1;
         end else if (!w_empty) begin
            w_pop    = 1'b1;
            w_start  = 1'b1;
            w_data   = SYNC_BYTE;
            rec_d    = mem_q[rd_ptr_q];
            idx_d    = 4'd1;
            active_d = 1'b1;
         end else begin
            active_d = 1'b0;
         end
      end
   end

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign w_push = obs.i_capture && (!full_q || w_pop);
   assign w_drop = obs.i_capture && full_q && !w_pop;

   always_comb begin
      wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (w_push && !w_pop)      count_d = count_q + 1'b1;
      else if (!w_push && w_pop) count_d = count_q - 1'b1;
      full_d   = (count_d == c_depth);
      drop_d   = (w_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= w_rec_in;
   end

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         drop_q   <= '0;
         active_q <= 1'b0;
         idx_q    <= '0;
         rec_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         drop_q   <= drop_d;
         active_q <= active_d;
         idx_q    <= idx_d;
         rec_q    <= rec_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk     (clk),
      .rst_n   (reset_in),
      .i_start (w_start),
      .i_data  (w_data),
      .o_ready (w_ready),
      .o_tx    (o_tx),
      .o_busy  (o_busy)
   );

   assign o_full       = full_q;
   assign o_drop_count = drop_q;

endmodule
`default_nettype wire

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
Debug trace consumer for the KLP32V1 processor's observation ports. On each capture strobe it snapshots one retired-instruction record (PC, instruction, write-back value, control flags) into a small record FIFO. It then serializes each record as a framed 8N1 UART byte stream to the host. It sits beside the processor in the board top and drives the board's UART TX pin.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range ≥2.
FIFO_DEPTH, 4, record FIFO depth; power of two, ≥2.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock
reset_in  input  1  asynchronous active-low reset
i_capture  input  1  single-cycle strobe; snapshot record inputs this cycle
i_pcOut  input  32  PC of retired instruction
i_inst  input  32  instruction word
i_writeBack  input  32  register write-back value
i_wb_select  input  2  write-back mux select
i_PCSel  input  1  PC select
i_BrEq  input  1  branch-equal flag
i_BrLT  input  1  branch-less-than flag
i_RegWEn  input  1  register write enable
i_memRW  input  1  data memory write
o_tx  output  1  UART serial out, idle high
o_busy  output  1  serializer not in IDLE
o_full  output  1  FIFO holds FIFO_DEPTH records
o_drop_count  output  8  records lost to full FIFO, saturating

Behaviour:
- Reset (async, reset_in=0): o_tx=1, o_busy=0, o_full=0, o_drop_count=0, FIFO empty, serializer IDLE, all counters 0. Assertion mid-frame aborts the frame immediately; no partial frame resumes after release.
- Flags byte: [7]=PCSel [6]=BrEq [5]=BrLT [4]=RegWEn [3]=memRW [2:1]=wb_select [0]=0.
- Frame: 14 bytes. Byte 0 = SYNC_BYTE. Bytes 1-4 = pc, bytes 5-8 = inst, bytes 9-12 = writeBack, each little-endian. Byte 13 = flags.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit held exactly CLKS_PER_BIT cycles. No idle gap between bytes of a frame.
- Frame duration: 140*CLKS_PER_BIT cycles. Back-to-back frames have no gap when the FIFO is non-empty at the end of a frame.
- Capture: i_capture=1 and not full at edge N writes the record. A capture strobe while full is dropped, and o_drop_count increments, saturating at 255.
- Pop: the serializer pops the head record at the IDLE->START transition.
- Simultaneous push and pop while full: the push is accepted and the count is unchanged. o_full stays 1 only if the count is still DEPTH.
- Serializer FSM:
  - IDLE: o_tx=1. On FIFO non-empty, load the record, byte_idx=0, go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift 8 bits, then go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<13, increment byte_idx and go to START. Otherwise, if the FIFO is non-empty, pop and go to START; else go to IDLE.
- Latency: with FIFO empty and FSM IDLE, capture at edge N is written at N. The FSM loads it at N+1, and o_tx is low from N+1.
- Outputs: o_tx is registered (glitch-free). o_busy = state≠IDLE. o_full is registered from the occupancy count.
- Pointer wrap: natural wrap modulo FIFO_DEPTH. Occupancy uses a log2(DEPTH)+1-bit count.

Decomposition:
- trace_pkg:
  - trace_rec_t packed struct {pc, inst, wb, flags} (104 bits)
  - FRAME_BYTES=14
  - tx_state_t enum {IDLE, START, DATA, STOP}
  - flag-bit index constants
- Sub-module uart_tx_byte: byte serializer with i_start/i_data/o_ready handshake and baud counter. trace_uart_tx owns the FIFO and frame byte sequencing.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset release, no capture for 1000 cycles -> o_tx stays 1, o_busy=0, o_drop_count=0.
2. Single capture: pc=32'h0000_0004, inst=32'h0050_0093, wb=32'h5, RegWEn=1, wb_select=2'b01. Required response:
   - o_tx low one cycle after capture.
   - Decoded bytes: A5 04 00 00 00 93 00 50 00 05 00 00 00 12.
   - Frame lasts exactly 560 cycles; then o_busy=0.
3. Six captures on consecutive cycles while idle -> first is popped at once; next 4 fill the FIFO (o_full=1); 6th dropped, o_drop_count=1. Six total frames? No: five frames back-to-back, no gap, in capture order.
4. FIFO full and a capture on the same cycle as a frame-end pop -> capture accepted, o_drop_count unchanged, o_full remains 1.
5. Assert reset_in=0 at byte 6 of a frame -> o_tx=1 in the same cycle (async). After release: FIFO empty, o_busy=0, no further bytes.
6. 300 captures with the FIFO held full -> o_drop_count saturates at 255.
